alpha_stream_engine: RTL and testbench
======================================

# alpha_stream_engine

Streaming, time-iterative forward-recursion (alpha) engine for the max-log-MAP turbo decoder. It accepts one symbol's branch metrics per cycle over a valid/ready handshake and computes the full alpha state vector for that symbol. It emits one normalised, saturated alpha vector per symbol to the downstream LLR/beta stage. It generalises the fixed-length unrolled alpha array to arbitrary frame length, parametrised RSC memory and polynomials, selectable initialisation and backpressure.

## Interface
Parameters:
- BITS, 10, signed two's-complement metric width.
- M, 2, encoder memory.
- STATES, 2**M, derived; do not override.
- FB, 3'o7, feedback taps, M+1 bits; bit M is the tap on the feedback node.
- FF, 3'o5, feedforward (parity) taps, M+1 bits.
- IDX_BITS, 12, width of the symbol index counter.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- init_mode, input, 1, initial vector: 0 = known state 0, 1 = uniform. Sampled on the first beat of a frame.
- in_valid, input, 1, branch metric beat valid.
- in_ready, output, 1, engine can accept a beat.
- in_last, input, 1, beat is the last symbol of the frame.
- branch_metric, input, [4][BITS], signed gamma values indexed {u,p} = 2*u+p.
- out_valid, output, 1, alpha vector valid.
- out_ready, input, 1, downstream accepts the vector.
- out_last, output, 1, vector belongs to the last symbol of the frame.
- out_index, output, IDX_BITS, 0-based symbol index within the frame; wraps modulo 2^IDX_BITS.
- alpha_metric, output, [STATES][BITS], alpha vector after the symbol.
- sat_flag, output, 1, sticky; set if any clamp occurred in the current frame.

## Operation
- Trellis: state s is M bits. For each s and input u:
  - a = u ^ ^(s & FB[M-1:0])
  - p = (FF[M] & a) ^ ^(s & FF[M-1:0])
  - next = {a, s[M-1:1]}
  - Every next state has exactly two predecessors.
- MIN = -2^(BITS-1) is reserved as minus-infinity. The legal finite range is [-2^(BITS-1)+1, 2^(BITS-1)-1].
- Internal register alpha_q[STATES] holds the previous alpha vector.
- Frame start is the first accepted beat after reset or after an accepted in_last beat. On that beat the previous vector is not taken from alpha_q:
  - init_mode=0: previous vector is [0, MIN, ..., MIN].
  - init_mode=1: previous vector is all 0.
  - sat_flag clears, and out_index for the beat is 0.
- Per accepted beat, for each (s,u), compute cand = prev[s] + gamma[2u+p] at BITS+2 width. If prev[s] == MIN, cand = MIN, so minus-infinity is sticky.
- raw[n] = max of the two candidates into n.
- Normalisation: subtract raw[0] from every finite raw[n]. If raw[0] == MIN, the offset is 0. MIN entries stay MIN.
- Clamp each finite result to the legal range. Any clamp sets sat_flag.
- The result is written to alpha_q and to the output register.
- out_last copies in_last. out_index increments per beat within a frame.

## Timing
- Reset values:
  - out_valid = 0, out_last = 0, out_index = 0, sat_flag = 0.
  - alpha_metric = all 0; alpha_q = all 0.
  - The frame-start flag is set.
- in_ready = !out_valid || out_ready, combinational. There is no other stall source.
- A beat is accepted when in_valid && in_ready. Its vector appears on the output registers on the next clock edge, so latency is 1 cycle.
- Sustained throughput is 1 symbol/cycle when out_ready is held at 1.
- The output holds stable while out_valid && !out_ready. in_ready is 0 in that condition.
- If a beat is accepted on the same cycle the output is consumed, the new vector replaces the old one with no bubble.
- Back-to-back frames are allowed: a frame-start beat may directly follow an in_last beat.
- An asynchronous reset mid-frame discards all state. The next beat is treated as a frame start.
- sat_flag updates with out_valid, so it reflects the frame up to and including the presented vector.

## Test plan
- Reset, then M=2 defaults, init_mode=0, gamma=[1,2,3,4], in_last=1 -> one cycle later out_valid=1, alpha=[0,MIN,3,MIN], out_index=0, out_last=1, sat_flag=0.
- Same setup, init_mode=1, gamma=[0,0,0,5] -> every state's best candidate uses gamma 0 or 5. Check alpha against the reference model; alpha[0]=0.
- 1000-symbol random frame with out_ready=1 -> 1000 vectors on consecutive cycles, out_index 0..999, out_last only on 999, bit-exact against the model.
- Random out_ready with 30% low -> no vector lost or duplicated; output stable while stalled; in_ready equals !out_valid||out_ready every cycle.
- BITS=6, gamma=[31,-31,31,-31] repeated -> values clamp to ±31, never -32 except true minus-infinity; sat_flag=1; sat_flag returns to 0 on the next frame's first vector.
- Assert rst_n low mid-frame at symbol 5, release, send init_mode=0 frame -> outputs restart at out_index 0 with the known-state-0 result; M=3, FB=4'o13, FF=4'o15 run bit-exact against the model.

Source files
------------

// File: rtl/alpha_stream_engine_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alpha_stream_engine_if : branch-metric input / alpha-vector output streams
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
interface alpha_stream_engine_if #(
    parameter int BITS     = 10,
    parameter int STATES   = 4,
    parameter int IDX_BITS = 12
);
    logic                        init_mode;
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_last;
    logic [3:0][BITS-1:0]        branch_metric;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;
    logic [IDX_BITS-1:0]         out_index;
    logic [STATES-1:0][BITS-1:0] alpha_metric;
    logic                        sat_flag;

    modport slave (
        input  init_mode, in_valid, in_last, branch_metric, out_ready,
        output in_ready, out_valid, out_last, out_index, alpha_metric, sat_flag
    );

    modport master (
        output init_mode, in_valid, in_last, branch_metric, out_ready,
        input  in_ready, out_valid, out_last, out_index, alpha_metric, sat_flag
    );
endinterface
`default_nettype wire

// File: rtl/alpha_stream_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alpha_stream_engine : streaming max-log-MAP forward (alpha) recursion
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module alpha_stream_engine #(
    parameter int         BITS     = 10,
    parameter int         M        = 2,
    parameter int         STATES   = 2**M,
    parameter logic [M:0] FB       = 3'o7,
    parameter logic [M:0] FF       = 3'o5,
    parameter int         IDX_BITS = 12
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    alpha_stream_engine_if.slave bus
);
    localparam int CW = BITS + 2;
    localparam int DW = BITS + 3;
    localparam logic signed [BITS-1:0] MIN_V   = {1'b1, {(BITS-1){1'b0}}};
    localparam logic signed [BITS-1:0] MAX_V   = {1'b0, {(BITS-1){1'b1}}};
    localparam logic signed [BITS-1:0] MIN_FIN = {1'b1, {(BITS-2){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_START = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                      state;
    logic [STATES-1:0][BITS-1:0] alpha_q;
    logic                        out_valid_q;
    logic                        out_last_q;
    logic [IDX_BITS-1:0]         out_index_q;
    logic                        sat_q;

    logic signed [BITS-1:0]      prev    [STATES];
    logic signed [CW-1:0]        raw     [STATES];
    logic                        raw_inf [STATES];
    logic [STATES-1:0][BITS-1:0] nxt;
    logic                        clamp_any;
    logic                        accept;

    assign bus.in_ready     = !out_valid_q || bus.out_ready;
    assign accept           = bus.in_valid && bus.in_ready;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_last     = out_last_q;
    assign bus.out_index    = out_index_q;
    assign bus.alpha_metric = alpha_q;
    assign bus.sat_flag     = sat_q;

    // The first beat of a frame starts from the selected initial vector.
    always_comb begin : p_prev
        for (int s = 0; s < STATES; s++) begin
            if (state == ST_START)
                prev[s] = (bus.init_mode || s == 0) ? '0 : MIN_V;
            else
                prev[s] = $signed(alpha_q[s]);
        end
    end

    // Add-compare-select; raw_inf marks states with no finite predecessor.
    always_comb begin : p_acs
        logic [M-1:0]         sv;
        logic [M-1:0]         ns;
        logic                 a;
        logic                 p;
        logic [1:0]           gi;
        logic signed [CW-1:0] cand;
        for (int n = 0; n < STATES; n++) begin
            raw[n]     = '0;
            raw_inf[n] = 1'b1;
        end
        for (int s = 0; s < STATES; s++) begin
            for (int u = 0; u < 2; u++) begin
                sv   = M'(s);
                a    = u[0] ^ (^(sv & FB[M-1:0]));
                p    = (FF[M] & a) ^ (^(sv & FF[M-1:0]));
                ns   = M'({a, sv} >> 1);
                gi   = {u[0], p};
                cand = CW'(prev[s]) + CW'($signed(bus.branch_metric[gi]));
                if (prev[s] != MIN_V && (raw_inf[ns] || cand > raw[ns])) begin
                    raw[ns]     = cand;
                    raw_inf[ns] = 1'b0;
                end
            end
        end
    end

    always_comb begin : p_norm
        logic signed [CW-1:0] offset;
        logic signed [DW-1:0] diff;
        offset    = raw_inf[0] ? '0 : raw[0];
        clamp_any = 1'b0;
        nxt       = '0;
        for (int n = 0; n < STATES; n++) begin
            diff   = DW'(raw[n]) - DW'(offset);
            nxt[n] = MIN_V;
            if (!raw_inf[n]) begin
                if (diff > DW'(MAX_V)) begin
                    nxt[n]    = MAX_V;
                    clamp_any = 1'b1;
                end else if (diff < DW'(MIN_FIN)) begin
                    nxt[n]    = MIN_FIN;
                    clamp_any = 1'b1;
                end else begin
                    nxt[n] = diff[BITS-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_START;
            alpha_q     <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_index_q <= '0;
            sat_q       <= 1'b0;
        end else if (accept) begin
            alpha_q     <= nxt;
            out_valid_q <= 1'b1;
            out_last_q  <= bus.in_last;
            out_index_q <= (state == ST_START) ? '0 : out_index_q + IDX_BITS'(1);
            sat_q       <= ((state == ST_RUN) && sat_q) || clamp_any;
            state       <= bus.in_last ? ST_START : ST_RUN;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_alpha_stream_engine.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alpha_stream_engine : directed vectors plus model-checked streams
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module tb_alpha_stream_engine;
    localparam int BA    = 10;
    localparam int MA    = 2;
    localparam int SA    = 4;
    localparam int BB    = 6;
    localparam int MB    = 3;
    localparam int SB    = 8;
    localparam int IDXW  = 12;
    localparam int MIN_A = -512;
    localparam int MIN_B = -32;

    typedef struct {
        bit ov;
        bit ir;
        bit ol;
        bit sf;
        int idx;
        int alpha [8];
    } obs_t;

    typedef struct {
        int alpha [8];
        int idx;
        bit last;
        bit sat;
    } exp_t;

    typedef struct {
        bit im;
        bit last;
        int g  [4];
        int ea [4];
        int eidx;
        bit elast;
        bit esat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    int mdl_alpha [2][8];
    bit mdl_start [2];
    bit mdl_sat   [2];
    int mdl_idx   [2];

    always #5 clk = ~clk;

    alpha_stream_engine_if #(.BITS(BA), .STATES(SA), .IDX_BITS(IDXW)) bus_a ();
    alpha_stream_engine_if #(.BITS(BB), .STATES(SB), .IDX_BITS(IDXW)) bus_b ();

    alpha_stream_engine #(.BITS(BA), .M(MA), .FB(3'o7), .FF(3'o5), .IDX_BITS(IDXW)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    alpha_stream_engine #(.BITS(BB), .M(MB), .FB(4'o13), .FF(4'o15), .IDX_BITS(IDXW)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic chk(input string name, input bit ok, input string got, input string want);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %s, required %s", name, got, want);
    endtask

    function automatic string fmt_vec(input int v [8], input int n);
        string s;
        s = "[";
        for (int i = 0; i < n; i++) begin
            s = {s, $sformatf("%0d", v[i])};
            if (i < n - 1) s = {s, ","};
        end
        s = {s, "]"};
        return s;
    endfunction

    function automatic string fmt_obs(input obs_t o, input int n);
        return $sformatf("valid=%0b alpha=%s idx=%0d last=%0b sat=%0b",
                         o.ov, fmt_vec(o.alpha, n), o.idx, o.ol, o.sf);
    endfunction

    function automatic string fmt_exp(input exp_t e, input int n);
        return $sformatf("valid=1 alpha=%s idx=%0d last=%0b sat=%0b",
                         fmt_vec(e.alpha, n), e.idx, e.last, e.sat);
    endfunction

    function automatic bit obs_match(input obs_t o, input exp_t e, input int n);
        bit ok;
        ok = o.ov && (o.idx == e.idx) && (o.ol == e.last) && (o.sf == e.sat);
        for (int s = 0; s < n; s++)
            if (o.alpha[s] != e.alpha[s]) ok = 1'b0;
        return ok;
    endfunction

    function automatic bit obs_same(input obs_t a, input obs_t b, input int n);
        bit ok;
        ok = (a.ov == b.ov) && (a.idx == b.idx) && (a.ol == b.ol) && (a.sf == b.sf);
        for (int s = 0; s < n; s++)
            if (a.alpha[s] != b.alpha[s]) ok = 1'b0;
        return ok;
    endfunction

    task automatic drive(input int sel, input bit v, input bit im, input bit last,
                         input int g [4], input bit ordy);
        if (sel == 0) begin
            bus_a.in_valid  = v;
            bus_a.init_mode = im;
            bus_a.in_last   = last;
            bus_a.out_ready = ordy;
            for (int k = 0; k < 4; k++) bus_a.branch_metric[k] = BA'(g[k]);
            bus_b.in_valid      = 1'b0;
            bus_b.init_mode     = 1'b0;
            bus_b.in_last       = 1'b0;
            bus_b.out_ready     = 1'b1;
            bus_b.branch_metric = '0;
        end else begin
            bus_b.in_valid  = v;
            bus_b.init_mode = im;
            bus_b.in_last   = last;
            bus_b.out_ready = ordy;
            for (int k = 0; k < 4; k++) bus_b.branch_metric[k] = BB'(g[k]);
            bus_a.in_valid      = 1'b0;
            bus_a.init_mode     = 1'b0;
            bus_a.in_last       = 1'b0;
            bus_a.out_ready     = 1'b1;
            bus_a.branch_metric = '0;
        end
    endtask

    task automatic sample(input int sel, output obs_t o);
        for (int s = 0; s < 8; s++) o.alpha[s] = 0;
        if (sel == 0) begin
            o.ov  = bus_a.out_valid;
            o.ir  = bus_a.in_ready;
            o.ol  = bus_a.out_last;
            o.sf  = bus_a.sat_flag;
            o.idx = int'(bus_a.out_index);
            for (int s = 0; s < SA; s++) o.alpha[s] = int'($signed(bus_a.alpha_metric[s]));
        end else begin
            o.ov  = bus_b.out_valid;
            o.ir  = bus_b.in_ready;
            o.ol  = bus_b.out_last;
            o.sf  = bus_b.sat_flag;
            o.idx = int'(bus_b.out_index);
            for (int s = 0; s < SB; s++) o.alpha[s] = int'($signed(bus_b.alpha_metric[s]));
        end
    endtask

    // Reference recursion written directly from the trellis definition.
    task automatic model_step(input int sel, input bit im, input bit last,
                              input int g [4], output exp_t e);
        int bits, m, fb, ff, ns, mn, mx, off, a, p, n, c, r;
        int prev [8];
        int best [8];
        bit fin  [8];
        bit clamp;
        bits  = (sel == 0) ? BA : BB;
        m     = (sel == 0) ? MA : MB;
        fb    = (sel == 0) ? 'o7 : 'o13;
        ff    = (sel == 0) ? 'o5 : 'o15;
        ns    = 1 << m;
        mn    = -(1 << (bits - 1));
        mx    = (1 << (bits - 1)) - 1;
        clamp = 1'b0;
        for (int s = 0; s < 8; s++) begin
            e.alpha[s] = 0;
            fin[s]     = 1'b0;
            best[s]    = 0;
            prev[s]    = 0;
        end
        for (int s = 0; s < ns; s++)
            prev[s] = mdl_start[sel] ? ((im || s == 0) ? 0 : mn) : mdl_alpha[sel][s];
        for (int s = 0; s < ns; s++) begin
            for (int u = 0; u < 2; u++) begin
                if (prev[s] != mn) begin
                    a = u ^ ($countones(s & fb & (ns - 1)) & 1);
                    p = (((ff >> m) & 1) & a) ^ ($countones(s & ff & (ns - 1)) & 1);
                    n = (a << (m - 1)) | (s >> 1);
                    c = prev[s] + g[2 * u + p];
                    if (!fin[n] || c > best[n]) begin
                        best[n] = c;
                        fin[n]  = 1'b1;
                    end
                end
            end
        end
        off = fin[0] ? best[0] : 0;
        for (int k = 0; k < ns; k++) begin
            if (!fin[k]) r = mn;
            else begin
                r = best[k] - off;
                if (r > mx) begin
                    r = mx;
                    clamp = 1'b1;
                end else if (r < mn + 1) begin
                    r = mn + 1;
                    clamp = 1'b1;
                end
            end
            e.alpha[k]          = r;
            mdl_alpha[sel][k]   = r;
        end
        mdl_sat[sel]   = (mdl_start[sel] ? 1'b0 : mdl_sat[sel]) | clamp;
        mdl_idx[sel]   = mdl_start[sel] ? 0 : ((mdl_idx[sel] + 1) % 4096);
        e.idx          = mdl_idx[sel];
        e.last         = last;
        e.sat          = mdl_sat[sel];
        mdl_start[sel] = last;
    endtask

    // One frame of nb beats; gmode 0 = random, 1 = clamp pattern, 2 = zeros.
    task automatic stream(input int sel, input int nb, input bit im, input int low_pct,
                          input int gmode, input string tag,
                          output bit first_sat, output bit last_sat);
        exp_t q [$];
        exp_t e;
        obs_t o, snap;
        int   g [4];
        int   sent, got, cyc, h, ns;
        bit   have, lst, ordy, stalled;
        sent = 0; got = 0; cyc = 0;
        have = 1'b0; lst = 1'b0; stalled = 1'b0;
        for (int k = 0; k < 4; k++) g[k] = 0;
        ns = (sel == 0) ? SA : SB;
        h  = 1 << (((sel == 0) ? BA : BB) - 2);
        mdl_start[sel] = 1'b1;
        first_sat = 1'b0;
        last_sat  = 1'b0;
        while (got < nb && cyc < 4 * nb + 50) begin
            @(negedge clk);
            if (!have && sent < nb) begin
                for (int k = 0; k < 4; k++) begin
                    case (gmode)
                        0:       g[k] = int'($urandom_range(2 * h)) - h;
                        1:       g[k] = (k % 2 == 0) ? 31 : -31;
                        default: g[k] = 0;
                    endcase
                end
                lst  = (sent == nb - 1);
                have = 1'b1;
            end
            ordy = ($urandom_range(99) >= low_pct);
            drive(sel, have, im, lst, g, ordy);
            #1;
            sample(sel, o);
            chk({tag, " in_ready"}, o.ir == (!o.ov || ordy),
                $sformatf("%0b", o.ir), $sformatf("%0b", !o.ov || ordy));
            if (stalled)
                chk({tag, " hold"}, obs_same(o, snap, ns), fmt_obs(o, ns), fmt_obs(snap, ns));
            if (low_pct == 0 && cyc > 0)
                chk({tag, " no_bubble"}, o.ov, $sformatf("%0b", o.ov), "1");
            if (o.ov && ordy) begin
                chk({tag, " expected_vector"}, q.size() != 0, "extra vector", "none pending");
                if (q.size() != 0) begin
                    e = q.pop_front();
                    chk($sformatf("%s vector%0d", tag, got), obs_match(o, e, ns),
                        fmt_obs(o, ns), fmt_exp(e, ns));
                    if (got == 0) first_sat = o.sf;
                    last_sat = o.sf;
                end
                got++;
            end
            stalled = o.ov && !ordy;
            snap    = o;
            if (have && o.ir) begin
                model_step(sel, im, lst, g, e);
                q.push_back(e);
                sent++;
                have = 1'b0;
            end
            cyc++;
        end
        chk({tag, " complete"}, got == nb, $sformatf("%0d vectors", got),
            $sformatf("%0d vectors", nb));
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 1'b0, g, 1'b1);
    endtask

    initial begin
        obs_t o;
        exp_t e;
        vec_t tbl [8];
        int   g [4];
        bit   fs, ls;

        tbl[0] = '{1'b0, 1'b1, '{1, 2, 3, 4},       '{0, MIN_A, 3, MIN_A},    0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, '{0, 0, 0, 5},       '{0, -5, 0, -5},          0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, '{1, 2, 3, 4},       '{0, 2, 3, 1},            1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, '{0, 0, 0, 0},       '{0, 1, 0, 1},            2, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, '{-511, 0, 0, 511},  '{0, MIN_A, 511, MIN_A},  0, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 1'b1, '{0, 0, 0, 0},       '{0, 511, 0, 511},        1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 1'b1, '{0, 0, 0, 0},       '{0, 0, 0, 0},            0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, '{511, 0, 0, -511},  '{0, MIN_A, -511, MIN_A}, 0, 1'b1, 1'b1};

        for (int k = 0; k < 4; k++) g[k] = 0;
        drive(0, 1'b0, 1'b0, 1'b0, g, 1'b1);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 8; s++) e.alpha[s] = 0;
        e.idx = 0; e.last = 1'b0; e.sat = 1'b0;
        sample(0, o);
        chk("reset_a", !o.ov && o.ir && obs_same(o, o, SA) && o.idx == 0 && !o.ol && !o.sf
            && o.alpha[0] == 0 && o.alpha[1] == 0 && o.alpha[2] == 0 && o.alpha[3] == 0,
            fmt_obs(o, SA), "valid=0 ready=1 alpha=[0,0,0,0] idx=0 last=0 sat=0");
        sample(1, o);
        chk("reset_b", !o.ov && o.ir && o.idx == 0 && !o.ol && !o.sf
            && fmt_vec(o.alpha, SB) == fmt_vec(e.alpha, SB),
            fmt_obs(o, SB), "valid=0 ready=1 alpha=0 idx=0 last=0 sat=0");

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(0, 1'b1, tbl[i].im, tbl[i].last, tbl[i].g, 1'b1);
            @(posedge clk);
            #1;
            sample(0, o);
            for (int s = 0; s < 4; s++) e.alpha[s] = tbl[i].ea[s];
            e.idx = tbl[i].eidx; e.last = tbl[i].elast; e.sat = tbl[i].esat;
            chk($sformatf("vec%0d", i), obs_match(o, e, SA), fmt_obs(o, SA), fmt_exp(e, SA));
        end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, g, 1'b1);

        g = '{31, -31, 31, -31};
        @(negedge clk);
        drive(1, 1'b1, 1'b0, 1'b1, g, 1'b1);
        @(posedge clk);
        #1;
        sample(1, o);
        e.alpha = '{0, MIN_B, MIN_B, MIN_B, -31, MIN_B, MIN_B, MIN_B};
        e.idx = 0; e.last = 1'b1; e.sat = 1'b1;
        chk("clamp_b_first", obs_match(o, e, SB), fmt_obs(o, SB), fmt_exp(e, SB));
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 1'b0, g, 1'b1);

        stream(1, 40, 1'b0, 0, 1, "clamp_b", fs, ls);
        chk("clamp_b sat_sticky", ls, $sformatf("%0b", ls), "1");
        stream(1, 3, 1'b1, 0, 2, "clear_b", fs, ls);
        chk("clear_b sat_cleared", !fs, $sformatf("%0b", fs), "0");

        stream(0, 1000, 1'b1, 0, 0, "full_a", fs, ls);
        stream(0, 300, 1'b0, 30, 0, "stall_a", fs, ls);
        stream(1, 1000, 1'b0, 30, 0, "stall_b", fs, ls);
        stream(1, 200, 1'b1, 0, 0, "full_b", fs, ls);

        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) g[k] = int'($urandom_range(200)) - 100;
            drive(0, 1'b1, 1'b1, 1'b0, g, 1'b1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sample(0, o);
        chk("async_reset", !o.ov && o.idx == 0 && !o.sf && !o.ol,
            fmt_obs(o, SA), "valid=0 idx=0 last=0 sat=0");
        @(negedge clk);
        rst_n = 1'b1;
        g = '{1, 2, 3, 4};
        drive(0, 1'b1, 1'b0, 1'b1, g, 1'b1);
        @(posedge clk);
        #1;
        sample(0, o);
        e.alpha = '{0, MIN_A, 3, MIN_A, 0, 0, 0, 0};
        e.idx = 0; e.last = 1'b1; e.sat = 1'b0;
        chk("restart_after_reset", obs_match(o, e, SA), fmt_obs(o, SA), fmt_exp(e, SA));
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, g, 1'b1);
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
`default_nettype wire
